// File: rtl/tdm_demux16_if.sv
// Bus bundle for the TDM 1-to-16 demultiplexer: serial slot input side plus
// the recovered parallel frame and status outputs.
interface tdm_demux16_if #(
    parameter int LANES = 16,
    parameter int SEL_W = 4
);
    logic             en;
    logic             sync;
    logic             din;
    logic [LANES-1:0] w;
    logic [SEL_W-1:0] s;
    logic             f_valid;
    logic             busy;
    logic             err;

    modport master (
        output en, sync, din,
        input  w, s, f_valid, busy, err
    );

    modport slave (
        input  en, sync, din,
        output w, s, f_valid, busy, err
    );
endinterface

// File: rtl/tdm_demux16.sv
// Time-division 1-to-16 demultiplexer: the slot counter steers each serial bit
// into a shadow register; the full frame is published to w with a valid pulse.
module tdm_demux16 #(
    parameter int LANES = 16,
    parameter int SEL_W = 4
) (
    input  logic         clk,
    input  logic         rstn,
    tdm_demux16_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [SEL_W-1:0] LAST = SEL_W'(LANES - 1);

    state_t           state_q, state_d;
    logic [LANES-1:0] shadow_q, shadow_d;
    logic [LANES-1:0] w_q, w_d;
    logic [SEL_W-1:0] s_q, s_d;
    logic             fv_q, fv_d;
    logic             err_q, err_d;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            w_q      <= '0;
            s_q      <= '0;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            w_q      <= w_d;
            s_q      <= s_d;
            fv_q     <= fv_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        w_d      = w_q;
        s_d      = s_q;
        fv_d     = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.en && bus.sync) begin
                    shadow_d = {{(LANES-1){1'b0}}, bus.din};
                    s_d      = SEL_W'(1);
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (bus.en) begin
                    // Sync mid-frame wins over completion, even in the last slot.
                    if (bus.sync) begin
                        err_d    = 1'b1;
                        shadow_d = {{(LANES-1){1'b0}}, bus.din};
                        s_d      = SEL_W'(1);
                    end else if (s_q == LAST) begin
                        w_d     = {bus.din, shadow_q[LANES-2:0]};
                        fv_d    = 1'b1;
                        s_d     = '0;
                        state_d = IDLE;
                    end else begin
                        shadow_d[s_q] = bus.din;
                        s_d           = s_q + SEL_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.w       = w_q;
    assign bus.s       = s_q;
    assign bus.f_valid = fv_q;
    assign bus.busy    = (state_q == RUN);
    assign bus.err     = err_q;
endmodule

// File: tb/tb_tdm_demux16.sv
// Directed bench for tdm_demux16: frames, back-to-back, stall, resync and reset.
module tb_tdm_demux16;
    logic clk = 1'b0;
    logic rstn = 1'b1;

    tdm_demux16_if #(.LANES(16), .SEL_W(4)) bus ();

    tdm_demux16 #(.LANES(16), .SEL_W(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int fv_cnt   = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int fv_cyc   = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One clock: apply inputs on the falling edge, observe just after the rising edge.
    task automatic drive(input logic e, input logic sy, input logic d);
        @(negedge clk);
        bus.en   = e;
        bus.sync = sy;
        bus.din  = d;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.f_valid) begin
            fv_cnt++;
            fv_cyc = cyc;
        end
        if (bus.err) err_cnt++;
        if (bus.f_valid && bus.err) both_cnt++;
    endtask

    task automatic run_frame(input logic [15:0] bits, input string tag);
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, (k == 0), bits[k]);
            if (k == 0) begin
                check({tag, "_s1"}, 32'(bus.s), 32'd1);
                check({tag, "_busy"}, 32'(bus.busy), 32'd1);
            end
        end
        check({tag, "_w"}, 32'(bus.w), 32'(bits));
        check({tag, "_fv"}, 32'(bus.f_valid), 32'd1);
        check({tag, "_s0"}, 32'(bus.s), 32'd0);
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int e0, fv0, er0, fc1;
        logic [15:0] bits;
        bus.en = 1'b0; bus.sync = 1'b0; bus.din = 1'b0;

        rstn = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        rstn = 1'b1;
        check("rst_w", 32'(bus.w), 32'd0);
        check("rst_s", 32'(bus.s), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_fv", 32'(bus.f_valid), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);

        run_frame(16'h0001, "f0001");
        drive(1'b0, 1'b0, 1'b0);
        check("f0001_fv_drop", 32'(bus.f_valid), 32'd0);
        check("f0001_w_hold", 32'(bus.w), 32'h0001);

        run_frame(16'h8000, "f8000");
        fc1 = fv_cyc;
        run_frame(16'h2000, "f2000");
        check("b2b_gap", 32'(fv_cyc - fc1), 32'd16);

        // Stall three cycles after slot 7.
        bits = 16'h0024;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, (k == 0), bits[k]);
            if (k == 0) e0 = cyc;
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b1);
            check("stall_s", 32'(bus.s), 32'd8);
            check("stall_w", 32'(bus.w), 32'h2000);
        end
        for (int k = 8; k < 16; k++) drive(1'b1, 1'b0, bits[k]);
        check("stall_w_final", 32'(bus.w), 32'h0024);
        check("stall_lat", 32'(fv_cyc - e0), 32'd18);

        // Resync at slot 9.
        fv0 = fv_cnt; er0 = err_cnt;
        for (int k = 0; k < 9; k++) drive(1'b1, (k == 0), 1'b1);
        check("rs9_s", 32'(bus.s), 32'd9);
        drive(1'b1, 1'b1, 1'b1);
        check("rs9_err", 32'(bus.err), 32'd1);
        check("rs9_fv", 32'(bus.f_valid), 32'd0);
        check("rs9_s1", 32'(bus.s), 32'd1);
        check("rs9_w_hold", 32'(bus.w), 32'h0024);
        for (int k = 1; k < 15; k++) drive(1'b1, 1'b0, 1'b0);
        check("rs9_err_drop", 32'(bus.err), 32'd0);
        check("rs9_w_pre", 32'(bus.w), 32'h0024);
        drive(1'b1, 1'b0, 1'b0);
        check("rs9_w", 32'(bus.w), 32'h0001);
        check("rs9_fv_end", 32'(bus.f_valid), 32'd1);
        check("rs9_fv_cnt", 32'(fv_cnt - fv0), 32'd1);
        check("rs9_err_cnt", 32'(err_cnt - er0), 32'd1);

        // Resync landing on the last slot must not complete the frame.
        for (int k = 0; k < 15; k++) drive(1'b1, (k == 0), 1'b0);
        check("rs15_s", 32'(bus.s), 32'd15);
        drive(1'b1, 1'b1, 1'b1);
        check("rs15_err", 32'(bus.err), 32'd1);
        check("rs15_fv", 32'(bus.f_valid), 32'd0);
        check("rs15_w_hold", 32'(bus.w), 32'h0001);
        check("rs15_s1", 32'(bus.s), 32'd1);
        for (int k = 1; k < 16; k++) drive(1'b1, 1'b0, (k == 15));
        check("rs15_w", 32'(bus.w), 32'h8001);

        // Reset mid-frame at s=6.
        fv0 = fv_cnt;
        for (int k = 0; k < 6; k++) drive(1'b1, (k == 0), 1'b1);
        check("mrst_s6", 32'(bus.s), 32'd6);
        rstn = 1'b0;
        drive(1'b1, 1'b0, 1'b1);
        rstn = 1'b1;
        check("mrst_w", 32'(bus.w), 32'd0);
        check("mrst_s", 32'(bus.s), 32'd0);
        check("mrst_busy", 32'(bus.busy), 32'd0);
        check("mrst_fv", 32'(bus.f_valid), 32'd0);
        for (int k = 0; k < 20; k++) drive(1'b1, 1'b0, 1'b1);
        check("mrst_post_w", 32'(bus.w), 32'd0);
        check("mrst_post_s", 32'(bus.s), 32'd0);
        check("mrst_post_busy", 32'(bus.busy), 32'd0);
        check("mrst_post_fv", 32'(fv_cnt - fv0), 32'd0);

        // en=0 in IDLE with sync and toggling din.
        fv0 = fv_cnt; er0 = err_cnt;
        for (int k = 0; k < 8; k++) drive(1'b0, 1'b1, k[0]);
        check("idle_s", 32'(bus.s), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_fv", 32'(fv_cnt - fv0), 32'd0);
        check("idle_err", 32'(err_cnt - er0), 32'd0);
        check("fv_err_excl", 32'(both_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/tdm_demux16.md
Name: tdm_demux16

Overview:
- Receive end of the 16:1 select path: a time-division 1-to-16 demultiplexer.
- A serial line carries one bit per slot. The slot counter plays the role of the mux select, so slot k is written to output lane w[k].
- After all 16 slots of a frame are captured, the full parallel word is presented with a one-cycle valid strobe.
- Sits downstream of the mux-based serialiser. Frame alignment comes from a sync pulse.

Parameters:
- LANES, 16, number of output lanes / slots per frame.
- SEL_W, 4, slot counter width; must satisfy 2**SEL_W == LANES.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rstn  input  1  reset, synchronous and active-low.
- en  input  1  slot enable; din is sampled only on cycles with en=1.
- sync  input  1  frame start marker, qualified by en; marks din as slot 0.
- din  input  1  serial data bit for the current slot.
- w  output  LANES  last complete frame; w[k] = bit received in slot k.
- s  output  SEL_W  current slot counter (next slot to be written).
- f_valid  output  1  one-cycle pulse, high in the cycle w is updated.
- busy  output  1  high while a frame is partially received (state RUN).
- err  output  1  one-cycle pulse on frame resync (sync seen mid-frame).

Behaviour:
- Reset (rstn=0 at a rising edge) has priority over all other inputs and takes effect at that edge:
  - w=0, s=0, f_valid=0, busy=0, err=0; shadow register=0; state=IDLE.
  - Reset mid-frame discards the partial frame; no f_valid follows.
- Shadow register:
  - Holds LANES bits of partial frame.
  - w changes only on frame completion.
- State IDLE (busy=0):
  - en=1 & sync=1: shadow[0]<=din, shadow[LANES-1:1]<=0, s<=1, state<=RUN.
  - Otherwise hold; din is ignored; s stays 0.
- State RUN (busy=1):
  - en=0: stall, all state held.
  - en=1 & sync=0 & s<LANES-1: shadow[s]<=din, s<=s+1.
  - en=1 & sync=0 & s==LANES-1:
    - w <= {din, shadow[LANES-2:0]} (slot 15 goes straight to w[15]).
    - f_valid<=1, s<=0 (wrap), state<=IDLE.
  - en=1 & sync=1, at any s (including s==LANES-1):
    - Resync: err<=1 and partial frame discarded; w is not updated and no f_valid.
    - shadow[0]<=din, other bits cleared, s<=1, stay RUN.
- Outputs:
  - f_valid and err are registered, each high for exactly one cycle after the triggering edge.
  - f_valid and err are never high in the same cycle.
- Latency: w and f_valid update at the same edge that samples slot 15, so they are visible in the cycle after slot 15 is presented.
- Back-to-back frames: en=1 & sync=1 in the cycle right after completion starts a new frame with no gap. The f_valid of the old frame and the slot-0 capture of the new frame happen on consecutive edges and both are honoured.
- w holds its value indefinitely between frames; en=0 in IDLE changes nothing.
- s is a plain binary counter, range 0..LANES-1; it never exceeds LANES-1.

Test Plan:
- Reset, then frame sync at slot 0, din=1 only in slot 0, en=1 for 16 cycles -> w=16'h0001, f_valid single pulse, s=0, busy=0 afterwards.
- Frame with din=1 only in slot 15 -> w=16'h8000; then frame with din=1 only in slot 13 -> w=16'h2000. Back-to-back frames (sync the cycle after completion) -> two f_valid pulses 16 cycles apart.
- Frame with din=1 in slots 2 and 5, en dropped for 3 cycles after slot 7 -> s holds at 8 during stall; completion is delayed 3 cycles; w=16'h0024.
- Sync reasserted at s=9 with din=1, then 15 more slots of din=0 -> err pulse at resync; no f_valid for the aborted frame; final w=16'h0001; prior w unchanged until then.
- rstn=0 asserted at s=6 mid-frame -> next cycle w=0, s=0, busy=0; no f_valid; din/en without sync afterwards produces no output change.
- en=0 with sync=1 and toggling din in IDLE -> no state change, s=0, busy=0, no pulses.
